// File: rtl/mcif_sdp_rd_port_if.sv
// Handshake bundle between the SDP read client, the MCIF read fabric and mcif_sdp_rd_port.
// slave = port-side view, master = environment (client + fabric) view.
interface mcif_sdp_rd_port_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 512,
  parameter int MASK_W = 2
);
  localparam int REQ_W = ADDR_W + 15;
  localparam int RSP_W = DATA_W + MASK_W;

  logic             sdp2mcif_rd_req_valid;
  logic             sdp2mcif_rd_req_ready;
  logic [REQ_W-1:0] sdp2mcif_rd_req_pd;
  logic             mcif2sdp_rd_rsp_valid;
  logic             mcif2sdp_rd_rsp_ready;
  logic [RSP_W-1:0] mcif2sdp_rd_rsp_pd;
  logic             sdp2mcif_rd_cdt_lat_fifo_pop;
  logic             mem_rd_req_valid;
  logic             mem_rd_req_ready;
  logic [REQ_W-1:0] mem_rd_req_pd;
  logic             mem_rd_rsp_valid;
  logic             mem_rd_rsp_ready;
  logic [RSP_W-1:0] mem_rd_rsp_pd;
  logic             cdt_err;
  logic             port_idle;

  modport slave (
    input  sdp2mcif_rd_req_valid, sdp2mcif_rd_req_pd,
    output sdp2mcif_rd_req_ready,
    output mcif2sdp_rd_rsp_valid, mcif2sdp_rd_rsp_pd,
    input  mcif2sdp_rd_rsp_ready,
    input  sdp2mcif_rd_cdt_lat_fifo_pop,
    output mem_rd_req_valid, mem_rd_req_pd,
    input  mem_rd_req_ready,
    input  mem_rd_rsp_valid, mem_rd_rsp_pd,
    output mem_rd_rsp_ready,
    output cdt_err, port_idle
  );

  modport master (
    output sdp2mcif_rd_req_valid, sdp2mcif_rd_req_pd,
    input  sdp2mcif_rd_req_ready,
    input  mcif2sdp_rd_rsp_valid, mcif2sdp_rd_rsp_pd,
    output mcif2sdp_rd_rsp_ready,
    output sdp2mcif_rd_cdt_lat_fifo_pop,
    input  mem_rd_req_valid, mem_rd_req_pd,
    output mem_rd_req_ready,
    output mem_rd_rsp_valid, mem_rd_rsp_pd,
    input  mem_rd_rsp_ready,
    input  cdt_err, port_idle
  );
endinterface

// File: rtl/mcif_sdp_rd_port.sv
// MCIF-side SDP read endpoint: credit-gated request pipe plus response FIFO.
// Credit gating is built only when NVDLA_MCIF_RD_CDT_GATE_EN is defined.
module mcif_sdp_rd_port #(
  parameter int ADDR_W         = 64,
  parameter int DATA_W         = 512,
  parameter int MASK_W         = 2,
  parameter int LAT_FIFO_DEPTH = 64,
  parameter int RSP_DEPTH      = 4
) (
  input  logic              nvdla_core_clk,
  input  logic              nvdla_core_rstn,
  mcif_sdp_rd_port_if.slave io_bus
);
  localparam int REQ_W = ADDR_W + 15;
  localparam int RSP_W = DATA_W + MASK_W;
  localparam int AW    = $clog2(RSP_DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic             w_credit_ok;
  logic             w_cdt_idle;
  logic             w_req_ready;
  logic             w_accept;
  logic             r_pipe_vld;
  logic [REQ_W-1:0] r_pipe_pd;

`ifdef NVDLA_MCIF_RD_CDT_GATE_EN
  localparam int CW = $clog2(LAT_FIFO_DEPTH + 1);
  localparam logic [CW-1:0] CDT_FULL = CW'(LAT_FIFO_DEPTH);

  logic [CW-1:0] r_cdt_cnt;
  logic          r_cdt_err;
  logic [15:0]   w_need;
  logic          w_oversize;
  logic          w_pop;
  logic          w_pop_drop;

  // size+1 is formed at 16 bits so the largest size never wraps to a small cost
  assign w_need      = {1'b0, io_bus.sdp2mcif_rd_req_pd[ADDR_W+14:ADDR_W]} + 16'd1;
  assign w_credit_ok = 16'(r_cdt_cnt) >= w_need;
  assign w_oversize  = w_need > 16'(LAT_FIFO_DEPTH);
  assign w_pop       = io_bus.sdp2mcif_rd_cdt_lat_fifo_pop;
  assign w_pop_drop  = w_pop && (r_cdt_cnt == CDT_FULL) && !w_accept;

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_cdt_cnt <= CDT_FULL;
      r_cdt_err <= 1'b0;
    end else begin
      if (w_accept)
        r_cdt_cnt <= r_cdt_cnt - CW'(w_need) + CW'(w_pop);
      else if (w_pop && !w_pop_drop)
        r_cdt_cnt <= r_cdt_cnt + CW'(1);
      if (w_pop_drop || (io_bus.sdp2mcif_rd_req_valid && w_oversize))
        r_cdt_err <= 1'b1;
    end
  end

  assign w_cdt_idle     = (r_cdt_cnt == CDT_FULL);
  assign io_bus.cdt_err = r_cdt_err;
`else
  logic [8:0] w_unused_nogate;

  assign w_unused_nogate = {io_bus.sdp2mcif_rd_cdt_lat_fifo_pop, 8'(LAT_FIFO_DEPTH)};
  assign w_credit_ok     = 1'b1;
  assign w_cdt_idle      = 1'b1;
  assign io_bus.cdt_err  = 1'b0;
`endif

  assign w_req_ready = w_credit_ok && (!r_pipe_vld || io_bus.mem_rd_req_ready);
  assign w_accept    = io_bus.sdp2mcif_rd_req_valid && w_req_ready;

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_pipe_vld <= 1'b0;
      r_pipe_pd  <= '0;
    end else if (w_accept) begin
      r_pipe_vld <= 1'b1;
      r_pipe_pd  <= io_bus.sdp2mcif_rd_req_pd;
    end else if (io_bus.mem_rd_req_ready) begin
      r_pipe_vld <= 1'b0;
    end
  end

  assign io_bus.sdp2mcif_rd_req_ready = w_req_ready;
  assign io_bus.mem_rd_req_valid      = r_pipe_vld;
  assign io_bus.mem_rd_req_pd         = r_pipe_pd;

  logic [RSP_W-1:0] r_mem [RSP_DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_empty;
  logic             w_full;
  logic             w_push;
  logic             w_pop_rsp;

  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push    = io_bus.mem_rd_rsp_valid && !w_full;
  assign w_pop_rsp = !w_empty && io_bus.mcif2sdp_rd_rsp_ready;

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int unsigned i = 0; i < RSP_DEPTH; i++)
        r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= io_bus.mem_rd_rsp_pd;
        r_wr_ptr                <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop_rsp)
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  assign io_bus.mem_rd_rsp_ready      = !w_full;
  assign io_bus.mcif2sdp_rd_rsp_valid = !w_empty;
  assign io_bus.mcif2sdp_rd_rsp_pd    = r_mem[r_rd_ptr[AW-1:0]];
  assign io_bus.port_idle             = w_cdt_idle && !r_pipe_vld && w_empty;
endmodule

// File: tb/tb_mcif_sdp_rd_port.sv
// Directed bench for mcif_sdp_rd_port; credit-gate checks build when NVDLA_MCIF_RD_CDT_GATE_EN is defined.
module tb_mcif_sdp_rd_port;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int MASK_W = 2;
  localparam int REQ_W  = ADDR_W + 15;
  localparam int RSP_W  = DATA_W + MASK_W;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  mcif_sdp_rd_port_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W)) bus ();

  mcif_sdp_rd_port #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W),
    .LAT_FIFO_DEPTH(8), .RSP_DEPTH(4)
  ) dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rstn(rstn),
    .io_bus         (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [REQ_W-1:0] mkreq(input logic [14:0] sz, input logic [15:0] a);
    return {sz, a};
  endfunction

  function automatic logic [RSP_W-1:0] mkrsp(input int k);
    return {2'(k), 32'hC0DE_0000 | 32'(k)};
  endfunction

  task automatic check_reset_state;
    chk("rst_req_ready", bus.sdp2mcif_rd_req_ready, 1);
    chk("rst_mem_vld",   bus.mem_rd_req_valid, 0);
    chk("rst_mem_pd",    bus.mem_rd_req_pd, 0);
    chk("rst_rsp_ready", bus.mem_rd_rsp_ready, 1);
    chk("rst_rsp_vld",   bus.mcif2sdp_rd_rsp_valid, 0);
    chk("rst_rsp_pd",    bus.mcif2sdp_rd_rsp_pd, 0);
    chk("rst_cdt_err",   bus.cdt_err, 0);
    chk("rst_idle",      bus.port_idle, 1);
  endtask

  initial begin
    bus.sdp2mcif_rd_req_valid        = 1'b0;
    bus.sdp2mcif_rd_req_pd           = '0;
    bus.mcif2sdp_rd_rsp_ready        = 1'b0;
    bus.sdp2mcif_rd_cdt_lat_fifo_pop = 1'b0;
    bus.mem_rd_req_ready             = 1'b0;
    bus.mem_rd_rsp_valid             = 1'b0;
    bus.mem_rd_rsp_pd                = '0;
    #2;
    check_reset_state();
    tick; tick;
    rstn = 1'b1;

    // request pipe: latency, throughput, backpressure
    bus.mem_rd_req_ready = 1'b1;
    bus.sdp2mcif_rd_req_valid = 1'b1;
    bus.sdp2mcif_rd_req_pd = mkreq(0, 16'h1111);
    settle;
    chk("p_rdy0", bus.sdp2mcif_rd_req_ready, 1);
    chk("p_idle0", bus.port_idle, 1);
    chk("p_vld0", bus.mem_rd_req_valid, 0);
    tick;
    bus.sdp2mcif_rd_req_pd = mkreq(0, 16'h2222);
    settle;
    chk("p_vld1", bus.mem_rd_req_valid, 1);
    chk("p_pdA", bus.mem_rd_req_pd, mkreq(0, 16'h1111));
    chk("p_rdy1", bus.sdp2mcif_rd_req_ready, 1);
    tick;
    bus.sdp2mcif_rd_req_valid = 1'b0;
    bus.mem_rd_req_ready = 1'b0;
    settle;
    chk("p_pdB", bus.mem_rd_req_pd, mkreq(0, 16'h2222));
    chk("p_vldB", bus.mem_rd_req_valid, 1);
    chk("p_bp_rdy", bus.sdp2mcif_rd_req_ready, 0);
    tick;
    bus.sdp2mcif_rd_req_valid = 1'b1;
    bus.sdp2mcif_rd_req_pd = mkreq(0, 16'h3333);
    settle;
    chk("p_bp_pd", bus.mem_rd_req_pd, mkreq(0, 16'h2222));
    chk("p_bp_rdy2", bus.sdp2mcif_rd_req_ready, 0);
    tick;
    settle;
    chk("p_bp_pd2", bus.mem_rd_req_pd, mkreq(0, 16'h2222));
    chk("p_bp_vld2", bus.mem_rd_req_valid, 1);
    bus.mem_rd_req_ready = 1'b1;
    settle;
    chk("p_rel_rdy", bus.sdp2mcif_rd_req_ready, 1);
    tick;
    bus.sdp2mcif_rd_req_valid = 1'b0;
    settle;
    chk("p_pdC", bus.mem_rd_req_pd, mkreq(0, 16'h3333));
    chk("p_vldC", bus.mem_rd_req_valid, 1);
    tick;
    settle;
    chk("p_drain_vld", bus.mem_rd_req_valid, 0);
`ifdef NVDLA_MCIF_RD_CDT_GATE_EN
    chk("p_idle_cdt", bus.port_idle, 0);
`else
    chk("p_idle_cdt", bus.port_idle, 1);
`endif

    // response FIFO: fill while client stalls, then drain in order
    bus.mem_rd_rsp_valid = 1'b1;
    bus.mem_rd_rsp_pd = mkrsp(0);
    settle;
    chk("f_mrdy0", bus.mem_rd_rsp_ready, 1);
    chk("f_nobypass", bus.mcif2sdp_rd_rsp_valid, 0);
    tick;
    bus.mem_rd_rsp_pd = mkrsp(1);
    settle;
    chk("f_vld1", bus.mcif2sdp_rd_rsp_valid, 1);
    chk("f_head0", bus.mcif2sdp_rd_rsp_pd, mkrsp(0));
    tick;
    bus.mem_rd_rsp_pd = mkrsp(2);
    tick;
    bus.mem_rd_rsp_pd = mkrsp(3);
    settle;
    chk("f_mrdy3", bus.mem_rd_rsp_ready, 1);
    tick;
    bus.mem_rd_rsp_pd = mkrsp(4);
    settle;
    chk("f_full", bus.mem_rd_rsp_ready, 0);
    chk("f_full_head", bus.mcif2sdp_rd_rsp_pd, mkrsp(0));
    tick;
    bus.mem_rd_rsp_valid = 1'b0;
    bus.mcif2sdp_rd_rsp_ready = 1'b1;
    settle;
    chk("f_full2", bus.mem_rd_rsp_ready, 0);
    chk("f_d0", bus.mcif2sdp_rd_rsp_pd, mkrsp(0));
    tick;
    settle;
    chk("f_d1", bus.mcif2sdp_rd_rsp_pd, mkrsp(1));
    chk("f_mrdy_back", bus.mem_rd_rsp_ready, 1);
    tick;
    bus.mem_rd_rsp_valid = 1'b1;
    bus.mem_rd_rsp_pd = mkrsp(5);
    settle;
    chk("f_d2", bus.mcif2sdp_rd_rsp_pd, mkrsp(2));
    tick;
    bus.mem_rd_rsp_valid = 1'b0;
    settle;
    chk("f_d3", bus.mcif2sdp_rd_rsp_pd, mkrsp(3));
    tick;
    settle;
    chk("f_d5", bus.mcif2sdp_rd_rsp_pd, mkrsp(5));
    chk("f_vld5", bus.mcif2sdp_rd_rsp_valid, 1);
    tick;
    settle;
    chk("f_empty", bus.mcif2sdp_rd_rsp_valid, 0);
    bus.mcif2sdp_rd_rsp_ready = 1'b0;

    // reset in the middle of traffic
    bus.mem_rd_req_ready = 1'b0;
    bus.sdp2mcif_rd_req_valid = 1'b1;
    bus.sdp2mcif_rd_req_pd = mkreq(0, 16'h4444);
    bus.mem_rd_rsp_valid = 1'b1;
    bus.mem_rd_rsp_pd = mkrsp(6);
    tick;
    bus.sdp2mcif_rd_req_valid = 1'b0;
    bus.mem_rd_rsp_valid = 1'b0;
    settle;
    chk("m_vld", bus.mem_rd_req_valid, 1);
    chk("m_pd", bus.mem_rd_req_pd, mkreq(0, 16'h4444));
    chk("m_rvld", bus.mcif2sdp_rd_rsp_valid, 1);
    chk("m_rpd", bus.mcif2sdp_rd_rsp_pd, mkrsp(6));
    chk("m_rdy", bus.sdp2mcif_rd_req_ready, 0);
    chk("m_idle", bus.port_idle, 0);
    rstn = 1'b0;
    settle;
    check_reset_state();
    tick;
    rstn = 1'b1;
    bus.mem_rd_req_ready = 1'b1;

`ifdef NVDLA_MCIF_RD_CDT_GATE_EN
    // credit exhaustion and single-pop recovery
    bus.sdp2mcif_rd_req_valid = 1'b1;
    bus.sdp2mcif_rd_req_pd = mkreq(3, 16'h0100);
    settle;
    chk("c_rdy_a", bus.sdp2mcif_rd_req_ready, 1);
    tick;
    bus.sdp2mcif_rd_req_pd = mkreq(3, 16'h0104);
    settle;
    chk("c_rdy_b", bus.sdp2mcif_rd_req_ready, 1);
    chk("c_pd_a", bus.mem_rd_req_pd, mkreq(3, 16'h0100));
    tick;
    bus.sdp2mcif_rd_req_pd = mkreq(0, 16'h0108);
    settle;
    chk("c_exhaust", bus.sdp2mcif_rd_req_ready, 0);
    tick;
    settle;
    chk("c_exhaust2", bus.sdp2mcif_rd_req_ready, 0);
    chk("c_pipe_drained", bus.mem_rd_req_valid, 0);
    bus.sdp2mcif_rd_cdt_lat_fifo_pop = 1'b1;
    settle;
    chk("c_pop_samecyc", bus.sdp2mcif_rd_req_ready, 0);
    tick;
    bus.sdp2mcif_rd_cdt_lat_fifo_pop = 1'b0;
    settle;
    chk("c_pop_next", bus.sdp2mcif_rd_req_ready, 1);
    tick;
    settle;
    chk("c_pd_g", bus.mem_rd_req_pd, mkreq(0, 16'h0108));
    chk("c_zero_again", bus.sdp2mcif_rd_req_ready, 0);
    bus.sdp2mcif_rd_req_valid = 1'b0;
    bus.sdp2mcif_rd_cdt_lat_fifo_pop = 1'b1;
    repeat (4) tick;
    bus.sdp2mcif_rd_cdt_lat_fifo_pop = 1'b0;
    bus.sdp2mcif_rd_req_pd = mkreq(3, 16'h0);
    settle;
    chk("c4_sz3", bus.sdp2mcif_rd_req_ready, 1);
    bus.sdp2mcif_rd_req_pd = mkreq(4, 16'h0);
    settle;
    chk("c4_sz4", bus.sdp2mcif_rd_req_ready, 0);

    // accept and pop in the same cycle
    bus.sdp2mcif_rd_req_valid = 1'b1;
    bus.sdp2mcif_rd_req_pd = mkreq(1, 16'h0200);
    bus.sdp2mcif_rd_cdt_lat_fifo_pop = 1'b1;
    settle;
    chk("s_rdy", bus.sdp2mcif_rd_req_ready, 1);
    tick;
    bus.sdp2mcif_rd_req_valid = 1'b0;
    bus.sdp2mcif_rd_cdt_lat_fifo_pop = 1'b0;
    bus.sdp2mcif_rd_req_pd = mkreq(2, 16'h0);
    settle;
    chk("s3_sz2", bus.sdp2mcif_rd_req_ready, 1);
    bus.sdp2mcif_rd_req_pd = mkreq(3, 16'h0);
    settle;
    chk("s3_sz3", bus.sdp2mcif_rd_req_ready, 0);
    bus.sdp2mcif_rd_req_valid = 1'b1;
    bus.sdp2mcif_rd_req_pd = mkreq(1, 16'h0204);
    tick;
    bus.sdp2mcif_rd_req_pd = mkreq(1, 16'h0208);
    bus.sdp2mcif_rd_cdt_lat_fifo_pop = 1'b1;
    settle;
    chk("s1_reg_cmp", bus.sdp2mcif_rd_req_ready, 0);
    tick;
    bus.sdp2mcif_rd_req_valid = 1'b0;
    bus.sdp2mcif_rd_cdt_lat_fifo_pop = 1'b0;
    settle;
    chk("s1_not_adm", bus.mem_rd_req_valid, 0);
    bus.sdp2mcif_rd_req_pd = mkreq(1, 16'h0);
    settle;
    chk("s2_sz1", bus.sdp2mcif_rd_req_ready, 1);
    bus.sdp2mcif_rd_req_pd = mkreq(2, 16'h0);
    settle;
    chk("s2_sz2", bus.sdp2mcif_rd_req_ready, 0);
    chk("s_err_clear", bus.cdt_err, 0);

    // overflow pop at full credit
    bus.sdp2mcif_rd_cdt_lat_fifo_pop = 1'b1;
    repeat (6) tick;
    bus.sdp2mcif_rd_cdt_lat_fifo_pop = 1'b0;
    bus.sdp2mcif_rd_req_pd = mkreq(7, 16'h0);
    settle;
    chk("o_full_idle", bus.port_idle, 1);
    chk("o_full_err", bus.cdt_err, 0);
    chk("o_full_sz7", bus.sdp2mcif_rd_req_ready, 1);
    bus.sdp2mcif_rd_cdt_lat_fifo_pop = 1'b1;
    tick;
    bus.sdp2mcif_rd_cdt_lat_fifo_pop = 1'b0;
    settle;
    chk("o_err", bus.cdt_err, 1);
    chk("o_idle", bus.port_idle, 1);
    chk("o_sz7", bus.sdp2mcif_rd_req_ready, 1);

    // oversize request
    rstn = 1'b0;
    settle;
    chk("z_rst_err", bus.cdt_err, 0);
    tick;
    rstn = 1'b1;
    bus.sdp2mcif_rd_req_pd = mkreq(8, 16'h0);
    settle;
    chk("z_sz8", bus.sdp2mcif_rd_req_ready, 0);
    bus.sdp2mcif_rd_req_pd = mkreq(15, 16'h0);
    settle;
    chk("z_sz15", bus.sdp2mcif_rd_req_ready, 0);
    bus.sdp2mcif_rd_req_pd = mkreq(15'h7FFF, 16'h0);
    settle;
    chk("z_szmax", bus.sdp2mcif_rd_req_ready, 0);
    chk("z_err_novld", bus.cdt_err, 0);
    bus.sdp2mcif_rd_req_pd = mkreq(7, 16'h0);
    settle;
    chk("z_sz7", bus.sdp2mcif_rd_req_ready, 1);
    bus.sdp2mcif_rd_req_valid = 1'b1;
    bus.sdp2mcif_rd_req_pd = mkreq(8, 16'h0300);
    settle;
    chk("z_rdy", bus.sdp2mcif_rd_req_ready, 0);
    tick;
    settle;
    chk("z_err", bus.cdt_err, 1);
    chk("z_vld", bus.mem_rd_req_valid, 0);
    chk("z_rdy2", bus.sdp2mcif_rd_req_ready, 0);
    tick;
    settle;
    chk("z_vld2", bus.mem_rd_req_valid, 0);
    bus.sdp2mcif_rd_req_valid = 1'b0;
`else
    // no credit gate: sustained large requests, pops ignored
    bus.sdp2mcif_rd_req_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      bus.sdp2mcif_rd_req_pd = mkreq(15, 16'(k * 4));
      settle;
      chk("n_rdy", bus.sdp2mcif_rd_req_ready, 1);
      if (k > 0)
        chk("n_pd", bus.mem_rd_req_pd, mkreq(15, 16'((k - 1) * 4)));
      tick;
    end
    bus.sdp2mcif_rd_req_valid = 1'b0;
    settle;
    chk("n_pd_last", bus.mem_rd_req_pd, mkreq(15, 16'(76)));
    chk("n_err", bus.cdt_err, 0);
    tick;
    settle;
    chk("n_vld_off", bus.mem_rd_req_valid, 0);
    chk("n_idle", bus.port_idle, 1);
    bus.sdp2mcif_rd_cdt_lat_fifo_pop = 1'b1;
    tick;
    bus.sdp2mcif_rd_cdt_lat_fifo_pop = 1'b0;
    settle;
    chk("n_pop_err", bus.cdt_err, 0);
    chk("n_pop_idle", bus.port_idle, 1);
    bus.sdp2mcif_rd_req_valid = 1'b1;
    bus.sdp2mcif_rd_req_pd = mkreq(15'h7FFF, 16'hBEEF);
    settle;
    chk("n_big_rdy", bus.sdp2mcif_rd_req_ready, 1);
    tick;
    bus.sdp2mcif_rd_req_valid = 1'b0;
    settle;
    chk("n_big_pd", bus.mem_rd_req_pd, mkreq(15'h7FFF, 16'hBEEF));
    chk("n_big_err", bus.cdt_err, 0);
    tick;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
